// File: rtl/pipe_run_ctrl_if.sv
// Run-control bundle between the pipeline run sequencer and its environment.
// master = sequencer side (samples requests, drives freeze/flush/status/counters).
interface pipe_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             halt_ex;
  logic             dbg_halt_req;
  logic             dbg_resume;
  logic             dbg_step;
  logic             retire;
  logic             pc_freeze;
  logic             fetch_flush;
  logic             running;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  halt_ex, dbg_halt_req, dbg_resume, dbg_step, retire,
    output pc_freeze, fetch_flush, running, halted, halt_cause, cycle_cnt, instret_cnt
  );

  modport slave (
    output halt_ex, dbg_halt_req, dbg_resume, dbg_step, retire,
    input  pc_freeze, fetch_flush, running, halted, halt_cause, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run-control sequencer for the 5-stage pipeline: run / drain / halt / single-step,
// with PC freeze + IF/ID NOP inject and cycle / retired-instruction counters.
module pipe_run_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32,
  parameter int START_HALTED = 0
) (
  input logic             clk,
  input logic             reset,
  pipe_run_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_DRAIN      = 3'd1,
    S_HALTED     = 3'd2,
    S_STEP_ISSUE = 3'd3,
    S_STEP_DRAIN = 3'd4
  } state_t;

  localparam logic   SH        = (START_HALTED != 0);
  localparam state_t RST_STATE = SH ? S_HALTED : S_RUN;

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [1:0]       cause_q, cause_d;
  logic             step_halt_q, step_halt_d;
  logic             freeze_q, running_q, halted_q;
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cause_d     = cause_q;
    step_halt_d = step_halt_q;
    case (state_q)
      S_RUN: begin
        if (bus.halt_ex) begin
          state_d = S_DRAIN;
          drain_d = 4'(DRAIN_CYCLES - 1);
          cause_d = 2'b01;
        end else if (bus.dbg_halt_req) begin
          state_d = S_DRAIN;
          drain_d = 4'(DRAIN_CYCLES - 1);
          cause_d = 2'b10;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) state_d = S_HALTED;
        else                 drain_d = drain_q - 4'd1;
      end
      S_HALTED: begin
        if (bus.dbg_resume) begin
          state_d = S_RUN;
          cause_d = 2'b00;
        end else if (bus.dbg_step) begin
          state_d     = S_STEP_ISSUE;
          drain_d     = 4'(DRAIN_CYCLES);
          step_halt_d = 1'b0;
        end
      end
      S_STEP_ISSUE: begin
        state_d = S_STEP_DRAIN;
        drain_d = drain_q - 4'd1;
      end
      S_STEP_DRAIN: begin
        // A halt instruction caught by the step outranks the step-complete cause.
        if (bus.halt_ex) step_halt_d = 1'b1;
        if (drain_q == 4'd0) begin
          state_d = S_HALTED;
          cause_d = (step_halt_q || bus.halt_ex) ? 2'b01 : 2'b11;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      drain_q     <= 4'd0;
      cause_q     <= 2'b00;
      step_halt_q <= 1'b0;
      freeze_q    <= SH;
      running_q   <= ~SH;
      halted_q    <= SH;
      cyc_q       <= '0;
      ret_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cause_q     <= cause_d;
      step_halt_q <= step_halt_d;
      freeze_q    <= !(state_d == S_RUN || state_d == S_STEP_ISSUE);
      running_q   <= (state_d == S_RUN);
      halted_q    <= (state_d == S_HALTED);
      if (state_q != S_HALTED) cyc_q <= cyc_q + CNT_W'(1);
      if (bus.retire)          ret_q <= ret_q + CNT_W'(1);
    end
  end

  // Mealy term stops the fetch right behind a halt instruction in EX.
  logic freeze_now;
  assign freeze_now = freeze_q | ((state_q == S_RUN) & bus.halt_ex);

  assign bus.pc_freeze   = reset ? SH  : freeze_now;
  assign bus.fetch_flush = reset ? SH  : freeze_now;
  assign bus.running     = reset ? ~SH : running_q;
  assign bus.halted      = reset ? SH  : halted_q;
  assign bus.halt_cause  = cause_q;
  assign bus.cycle_cnt   = cyc_q;
  assign bus.instret_cnt = ret_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed + random bench for pipe_run_ctrl: three instances (default, CNT_W=4/D=2,
// START_HALTED/D=1) share stimulus and are scored against a per-cycle behavioural model.
module tb_pipe_run_ctrl;

  logic clk = 1'b0;
  logic reset, halt_ex, dbg_halt_req, dbg_resume, dbg_step, retire;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_run_ctrl_if #(.CNT_W(32)) if0 ();
  pipe_run_ctrl_if #(.CNT_W(4))  if1 ();
  pipe_run_ctrl_if #(.CNT_W(32)) if2 ();

  assign if0.halt_ex = halt_ex;  assign if0.dbg_halt_req = dbg_halt_req;
  assign if0.dbg_resume = dbg_resume;  assign if0.dbg_step = dbg_step;  assign if0.retire = retire;
  assign if1.halt_ex = halt_ex;  assign if1.dbg_halt_req = dbg_halt_req;
  assign if1.dbg_resume = dbg_resume;  assign if1.dbg_step = dbg_step;  assign if1.retire = retire;
  assign if2.halt_ex = halt_ex;  assign if2.dbg_halt_req = dbg_halt_req;
  assign if2.dbg_resume = dbg_resume;  assign if2.dbg_step = dbg_step;  assign if2.retire = retire;

  pipe_run_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32), .START_HALTED(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  pipe_run_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4),  .START_HALTED(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  pipe_run_ctrl #(.DRAIN_CYCLES(1), .CNT_W(32), .START_HALTED(1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic        o_frz[3], o_fl[3], o_run[3], o_hlt[3];
  logic [1:0]  o_cause[3];
  logic [31:0] o_cyc[3], o_ret[3];

  assign o_frz[0] = if0.pc_freeze;   assign o_fl[0] = if0.fetch_flush;
  assign o_run[0] = if0.running;     assign o_hlt[0] = if0.halted;
  assign o_cause[0] = if0.halt_cause;
  assign o_cyc[0] = if0.cycle_cnt;   assign o_ret[0] = if0.instret_cnt;
  assign o_frz[1] = if1.pc_freeze;   assign o_fl[1] = if1.fetch_flush;
  assign o_run[1] = if1.running;     assign o_hlt[1] = if1.halted;
  assign o_cause[1] = if1.halt_cause;
  assign o_cyc[1] = {28'd0, if1.cycle_cnt};  assign o_ret[1] = {28'd0, if1.instret_cnt};
  assign o_frz[2] = if2.pc_freeze;   assign o_fl[2] = if2.fetch_flush;
  assign o_run[2] = if2.running;     assign o_hlt[2] = if2.halted;
  assign o_cause[2] = if2.halt_cause;
  assign o_cyc[2] = if2.cycle_cnt;   assign o_ret[2] = if2.instret_cnt;

  // Reference model: mode 0 running, 1 stopping, 2 parked, 3 stepping.
  // "left" counts the non-halted cycles still to go before parking.
  int     P_D[3]    = '{3, 2, 1};
  int     P_SH[3]   = '{0, 0, 1};
  longint P_MOD[3]  = '{64'h1_0000_0000, 64'd16, 64'h1_0000_0000};
  int     m_mode[3], m_left[3], m_cause[3], m_hf[3];
  longint m_cyc[3], m_ret[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int k);
    logic e_frz;
    if (reset)              e_frz = (P_SH[k] != 0);
    else if (m_mode[k] == 0) e_frz = halt_ex;
    else                    e_frz = !(m_mode[k] == 3 && m_left[k] == P_D[k] + 1);
    chk($sformatf("freeze%0d", k), 64'(o_frz[k]), 64'(e_frz));
    chk($sformatf("flush%0d", k),  64'(o_fl[k]),  64'(e_frz));
    chk($sformatf("running%0d", k), 64'(o_run[k]),
        reset ? 64'(P_SH[k] == 0) : 64'(m_mode[k] == 0));
    chk($sformatf("halted%0d", k), 64'(o_hlt[k]),
        reset ? 64'(P_SH[k] != 0) : 64'(m_mode[k] == 2));
    chk($sformatf("cause%0d", k),  64'(o_cause[k]), 64'(m_cause[k]));
    chk($sformatf("cycle%0d", k),  64'(o_cyc[k]),   64'(m_cyc[k]));
    chk($sformatf("instret%0d", k), 64'(o_ret[k]),  64'(m_ret[k]));
  endtask

  task automatic model_edge(input int k);
    if (reset) begin
      m_mode[k] = (P_SH[k] != 0) ? 2 : 0;
      m_cause[k] = 0; m_left[k] = 0; m_hf[k] = 0;
      m_cyc[k] = 0;   m_ret[k] = 0;
      return;
    end
    if (m_mode[k] != 2) m_cyc[k] = (m_cyc[k] + 1) % P_MOD[k];
    if (retire)         m_ret[k] = (m_ret[k] + 1) % P_MOD[k];
    case (m_mode[k])
      0: if (halt_ex || dbg_halt_req) begin
           m_mode[k] = 1; m_left[k] = P_D[k]; m_cause[k] = halt_ex ? 1 : 2;
         end
      1: begin
           m_left[k]--;
           if (m_left[k] == 0) m_mode[k] = 2;
         end
      2: if (dbg_resume) begin
           m_mode[k] = 0; m_cause[k] = 0;
         end else if (dbg_step) begin
           m_mode[k] = 3; m_left[k] = P_D[k] + 1; m_hf[k] = 0;
         end
      default: begin
           if (m_left[k] != P_D[k] + 1 && halt_ex) m_hf[k] = 1;
           m_left[k]--;
           if (m_left[k] == 0) begin
             m_mode[k] = 2; m_cause[k] = m_hf[k] ? 1 : 3;
           end
         end
    endcase
  endtask

  task automatic cyc_step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_inst(k);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
  endtask

  initial begin
    int n_open;
    logic pat [10];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    reset = 1'b1; halt_ex = 1'b0; dbg_halt_req = 1'b0;
    dbg_resume = 1'b0; dbg_step = 1'b0; retire = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    cyc_step();
    reset = 1'b0;

    // Free run: 10 cycles, 6 retirements.
    for (int i = 0; i < 10; i++) begin
      retire = pat[i];
      cyc_step();
    end
    retire = 1'b0;
    chk("run_cyc10", 64'(if0.cycle_cnt), 64'd10);
    chk("run_ret6", 64'(if0.instret_cnt), 64'd6);
    chk("run_running", 64'(if0.running), 64'd1);

    // Halt instruction at cycle 20.
    repeat (10) cyc_step();
    halt_ex = 1'b1;
    #1;
    chk("mealy_freeze", 64'(if0.pc_freeze), 64'd1);
    chk("mealy_flush", 64'(if0.fetch_flush), 64'd1);
    cyc_step();
    halt_ex = 1'b0;
    chk("drain_not_running", 64'(if0.running), 64'd0);
    repeat (3) cyc_step();
    chk("halt_halted", 64'(if0.halted), 64'd1);
    chk("halt_cause01", 64'(if0.halt_cause), 64'd1);
    chk("halt_cyc24", 64'(if0.cycle_cnt), 64'd24);
    repeat (2) cyc_step();
    chk("halt_cyc_frozen", 64'(if0.cycle_cnt), 64'd24);

    // Single step.
    dbg_step = 1'b1;
    cyc_step();
    dbg_step = 1'b0;
    n_open = 0;
    for (int i = 0; i < 5; i++) begin
      if (if0.pc_freeze == 1'b0) n_open++;
      if (i == 3) chk("step_not_yet_halted", 64'(if0.halted), 64'd0);
      cyc_step();
    end
    chk("step_one_fetch", 64'(n_open), 64'd1);
    chk("step_halted", 64'(if0.halted), 64'd1);
    chk("step_cause11", 64'(if0.halt_cause), 64'd3);
    chk("step_cyc28", 64'(if0.cycle_cnt), 64'd28);

    // Resume, then halt_ex and debug request together.
    dbg_resume = 1'b1;
    cyc_step();
    dbg_resume = 1'b0;
    chk("resume_cause00", 64'(if0.halt_cause), 64'd0);
    halt_ex = 1'b1; dbg_halt_req = 1'b1;
    cyc_step();
    halt_ex = 1'b0; dbg_halt_req = 1'b0;
    repeat (3) cyc_step();
    chk("prio_halted", 64'(if0.halted), 64'd1);
    chk("prio_cause01", 64'(if0.halt_cause), 64'd1);
    dbg_resume = 1'b1; dbg_step = 1'b1;
    cyc_step();
    dbg_resume = 1'b0; dbg_step = 1'b0;
    chk("both_running", 64'(if0.running), 64'd1);
    chk("both_cause00", 64'(if0.halt_cause), 64'd0);

    // Reset in the second drain cycle.
    halt_ex = 1'b1;
    cyc_step();
    halt_ex = 1'b0;
    cyc_step();
    reset = 1'b1;
    cyc_step();
    reset = 1'b0;
    chk("rst_running", 64'(if0.running), 64'd1);
    chk("rst_cyc0", 64'(if0.cycle_cnt), 64'd0);
    chk("rst_cause00", 64'(if0.halt_cause), 64'd0);
    chk("rst_freeze0", 64'(if0.pc_freeze), 64'd0);
    chk("rst_sh_halted", 64'(if2.halted), 64'd1);
    chk("rst_sh_freeze", 64'(if2.pc_freeze), 64'd1);

    // 4-bit counter wrap after 17 non-halted cycles.
    repeat (17) cyc_step();
    chk("wrap_cyc1", 64'(if1.cycle_cnt), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      halt_ex    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 24) == 0) dbg_halt_req = ~dbg_halt_req;
      dbg_resume = ($urandom_range(0, 5) == 0);
      dbg_step   = ($urandom_range(0, 4) == 0);
      retire     = ($urandom_range(0, 1) == 0);
      reset      = ($urandom_range(0, 149) == 0);
      cyc_step();
    end
    reset = 1'b0; halt_ex = 1'b0; dbg_halt_req = 1'b0;
    dbg_resume = 1'b0; dbg_step = 1'b0; retire = 1'b0;
    cyc_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
